data_sram_resp: RTL and testbench
=================================

# data_sram_resp

Responder for the data-side SRAM-like request/response interface driven by the EXE stage. It accepts `data_sram_req` transactions with `data_sram_addr_ok`, performs reads and byte-masked writes on an internal word-addressed RAM, and returns in-order `data_sram_data_ok` responses with `data_sram_rdata` after a configurable latency. It stands in for the data SRAM on the CPU side of the SoC and backs the MEM stage's response consumption, both in simulation and in FPGA bring-up.

## Interface
- `ADDR_W`, 10: word-address bits; RAM holds 2^ADDR_W 32-bit words.
- `DEPTH`, 2: maximum outstanding accepted-but-unanswered requests (≥1).
- `ADDR_DELAY`, 0: cycles `req` must be held high before `addr_ok` may assert.
- `DATA_DELAY`, 1: minimum cycles from acceptance to `data_ok` (≥1).

- `clk`  in  1  sole clock; all state on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `data_sram_req`  in  1  request valid.
- `data_sram_wr`  in  1  1 = write, 0 = read.
- `data_sram_size`  in  2  {word, half}; informational, not used for masking.
- `data_sram_wstrb`  in  4  byte enables for writes; ignored on reads.
- `data_sram_addr`  in  32  byte address; word index = addr[ADDR_W+1:2], other bits ignored.
- `data_sram_wdata`  in  32  write data, byte lanes already replicated by requester.
- `data_sram_addr_ok`  out  1  request accepted this cycle when high together with `req`.
- `data_sram_data_ok`  out  1  one-cycle response pulse, in acceptance order.
- `data_sram_rdata`  out  32  read data, valid only when `data_ok` and response is for a read; 0 otherwise.

## Operation
- Accept = `req & addr_ok` on a posedge. `addr_ok = req & ~reset & (wait_cnt >= ADDR_DELAY) & (count < DEPTH | pop)`, where `pop` = head response issued this cycle (slot freed same cycle).
- `wait_cnt`: increments (saturating at ADDR_DELAY) each cycle `req` high and not accepted; cleared on accept or when `req` low. ADDR_DELAY=0 → `addr_ok` purely combinational on req/full.
- On accept: write → RAM[idx] updated per byte where `wstrb[i]`; read → RAM[idx] sampled at accept (post any earlier accepted writes) into the entry. Entry pushed to response FIFO as {wr, data, timer = DATA_DELAY-1}.
- Response FIFO: circular, DEPTH entries, head/tail pointers wrapping mod DEPTH, `count` 0..DEPTH. Each cycle every valid entry's timer decrements if nonzero.
- Head responds (`pop`) when `count != 0` and head timer == 0: `data_ok = 1`, `rdata = wr ? 0 : data`. At most one response per cycle; later entries whose timer hit 0 wait.
- Simultaneous push and pop: count unchanged, both pointers advance. Push into empty FIFO never responds in the same cycle (DATA_DELAY ≥ 1).
- Write with `wstrb == 0`: accepted, RAM unchanged, still gets `data_ok`.
- `reset`: count, pointers, timers, `wait_cnt` cleared; outstanding responses discarded. RAM contents are not reset (zero-initialised in simulation only).

## Timing
- Reset values: `addr_ok` 0, `data_ok` 0, `rdata` 0.
- Accept at cycle T → `data_ok` at T+DATA_DELAY earliest; later if older responses are queued (strict in-order, one per cycle).
- Steady streaming with DEPTH ≥ DATA_DELAY and ADDR_DELAY=0: one accept and one response per cycle.
- Full (count==DEPTH) and no pop: `addr_ok` 0, `req` must stay held; acceptance the cycle head pops.
- `addr_ok` and `data_ok` are combinational from registered state plus `req`; no combinational path from `data_ok` to any input.
- Reset asserted mid-burst: next cycle after reset deasserts, `data_ok` is 0 until a new acceptance + DATA_DELAY.

## Test plan
- Single read, DATA_DELAY=1: preload RAM[4]=0x12345678, req read addr 0x10 at T → `addr_ok` at T, `data_ok`=1, `rdata`=0x12345678 at T+1, low at T+2.
- Byte write then read: write addr 0x10 wstrb 4'b0010 wdata 0xAAAAAAAA (RAM[4]=0x12345678) → read returns 0x1234AA78; write response `rdata`=0.
- Backpressure, DEPTH=2, DATA_DELAY=3: four back-to-back reads → accepts at T, T+1, third accepted at T+3 (pop of first), responses at T+3, T+4, T+6, T+7, in order.
- ADDR_DELAY=2: req held from T → `addr_ok` first at T+2; drop req at T+1 and re-raise → counter restarts.
- Reset mid-flight: two reads outstanding, assert `reset` one cycle → no `data_ok` for them afterward; RAM written earlier still reads back its value.
- Out-of-range address bits: write 0xDEADBEEF to 0x8000_0010 (ADDR_W=10), read 0x0000_0010 → 0xDEADBEEF.

Source files
------------

// File: rtl/data_sram_resp_if.sv
// Data-side SRAM-like request/response bus between the EXE/MEM requester and
// the responder. Signal names follow the CPU-side data_sram_* convention.
interface data_sram_resp_if;
  // Handshake: a request is taken on a posedge where req and addr_ok are both
  // high; the requester holds req and its payload stable until then. data_ok
  // is a single-cycle pulse per accepted request, returned in acceptance order,
  // with no ready signal from the requester.
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/data_sram_resp.sv
// Word-addressed RAM behind the data SRAM-like bus: byte-masked writes, reads
// sampled at acceptance, in-order responses after a fixed minimum latency.
module data_sram_resp #(
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 2,
  parameter int ADDR_DELAY = 0,
  parameter int DATA_DELAY = 1
) (
  input  logic             clk,
  input  logic             reset,
  data_sram_resp_if.slave  bus
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int TMR_W  = (DATA_DELAY > 1) ? $clog2(DATA_DELAY) : 1;
  localparam int WAIT_W = (ADDR_DELAY > 0) ? $clog2(ADDR_DELAY + 1) : 1;

  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0]  TMR_INIT = TMR_W'(DATA_DELAY - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(ADDR_DELAY);

  logic [31:0]       mem_q [2**ADDR_W];

  logic [DEPTH-1:0]  wr_q;
  logic [31:0]       data_q [DEPTH];
  logic [TMR_W-1:0]  tmr_q  [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              delay_ok;
  logic              pop;
  logic              push;
  logic [ADDR_W-1:0] idx;
  logic              unused_bits;

  assign idx = bus.data_sram_addr[ADDR_W+1:2];
  assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr};

  if (ADDR_DELAY == 0) begin : g_no_addr_delay
    assign delay_ok = 1'b1;
  end else begin : g_addr_delay
    assign delay_ok = (wait_q == WAIT_MAX);
  end

  // The head slot frees in the same cycle it responds, so a full queue can
  // still accept while popping.
  assign pop  = ~reset & (cnt_q != '0) & (tmr_q[head_q] == '0);
  assign push = bus.data_sram_req & bus.data_sram_addr_ok;

  assign bus.data_sram_addr_ok = bus.data_sram_req & ~reset & delay_ok &
                                 ((cnt_q != FULL_CNT) | pop);
  assign bus.data_sram_data_ok = pop;
  assign bus.data_sram_rdata   = (pop & ~wr_q[head_q]) ? data_q[head_q] : 32'h0;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    wait_d = wait_q;
    if (pop)  head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
    if (push) tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    if (push || !bus.data_sram_req) wait_d = '0;
    else if (wait_q != WAIT_MAX)    wait_d = wait_q + WAIT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      wait_q <= '0;
      for (int i = 0; i < DEPTH; i++) tmr_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      wait_q <= wait_d;
      // Stale slots also count down; a push always reloads its timer.
      for (int i = 0; i < DEPTH; i++) begin
        if (tmr_q[i] != '0) tmr_q[i] <= tmr_q[i] - TMR_W'(1);
      end
      if (push) begin
        wr_q[tail_q]   <= bus.data_sram_wr;
        data_q[tail_q] <= mem_q[idx];
        tmr_q[tail_q]  <= TMR_INIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && bus.data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_sram_wstrb[b]) mem_q[idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Drives three differently-parameterised responders and compares every cycle
// against a queue-based model of the acceptance and response rules.
module tb_data_sram_resp;

  localparam int N = 3;
  localparam int AD0 = 0, DP0 = 2, DD0 = 1;
  localparam int AD1 = 0, DP1 = 2, DD1 = 3;
  localparam int AD2 = 2, DP2 = 3, DD2 = 2;

  int ad_m  [N] = '{AD0, AD1, AD2};
  int dep_m [N] = '{DP0, DP1, DP2};
  int dd_m  [N] = '{DD0, DD1, DD2};

  logic clk;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic        rst_s  [N];
  logic        req_s  [N];
  logic        wr_s   [N];
  logic [1:0]  size_s [N];
  logic [3:0]  strb_s [N];
  logic [31:0] addr_s [N];
  logic [31:0] wd_s   [N];
  logic        aok_s  [N];
  logic        dok_s  [N];
  logic [31:0] rd_s   [N];

  typedef struct {
    int          due;
    bit          wr;
    logic [31:0] data;
  } resp_t;

  resp_t     rq     [N][$];
  bit [31:0] mem_m  [N][1024];
  int        wait_m [N];
  int        acc_q  [N][$];
  int        ok_q   [N][$];
  int        last_acc [N];

  data_sram_resp_if if_a ();
  data_sram_resp_if if_b ();
  data_sram_resp_if if_c ();

  assign if_a.data_sram_req = req_s[0];  assign if_a.data_sram_wr = wr_s[0];
  assign if_a.data_sram_size = size_s[0]; assign if_a.data_sram_wstrb = strb_s[0];
  assign if_a.data_sram_addr = addr_s[0]; assign if_a.data_sram_wdata = wd_s[0];
  assign aok_s[0] = if_a.data_sram_addr_ok; assign dok_s[0] = if_a.data_sram_data_ok;
  assign rd_s[0] = if_a.data_sram_rdata;

  assign if_b.data_sram_req = req_s[1];  assign if_b.data_sram_wr = wr_s[1];
  assign if_b.data_sram_size = size_s[1]; assign if_b.data_sram_wstrb = strb_s[1];
  assign if_b.data_sram_addr = addr_s[1]; assign if_b.data_sram_wdata = wd_s[1];
  assign aok_s[1] = if_b.data_sram_addr_ok; assign dok_s[1] = if_b.data_sram_data_ok;
  assign rd_s[1] = if_b.data_sram_rdata;

  assign if_c.data_sram_req = req_s[2];  assign if_c.data_sram_wr = wr_s[2];
  assign if_c.data_sram_size = size_s[2]; assign if_c.data_sram_wstrb = strb_s[2];
  assign if_c.data_sram_addr = addr_s[2]; assign if_c.data_sram_wdata = wd_s[2];
  assign aok_s[2] = if_c.data_sram_addr_ok; assign dok_s[2] = if_c.data_sram_data_ok;
  assign rd_s[2] = if_c.data_sram_rdata;

  data_sram_resp #(.ADDR_W(10), .DEPTH(DP0), .ADDR_DELAY(AD0), .DATA_DELAY(DD0))
    u_dut_a (.clk(clk), .reset(rst_s[0]), .bus(if_a));
  data_sram_resp #(.ADDR_W(10), .DEPTH(DP1), .ADDR_DELAY(AD1), .DATA_DELAY(DD1))
    u_dut_b (.clk(clk), .reset(rst_s[1]), .bus(if_b));
  data_sram_resp #(.ADDR_W(10), .DEPTH(DP2), .ADDR_DELAY(AD2), .DATA_DELAY(DD2))
    u_dut_c (.clk(clk), .reset(rst_s[2]), .bus(if_c));

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      bit          pop_e;
      bit          acc_e;
      int          idx;
      logic [31:0] exp_rd;
      resp_t       ent;
      pop_e  = (rq[k].size() > 0) && !rst_s[k] && (rq[k][0].due <= cyc);
      acc_e  = req_s[k] && !rst_s[k] && (wait_m[k] >= ad_m[k]) &&
               ((rq[k].size() < dep_m[k]) || pop_e);
      exp_rd = (pop_e && !rq[k][0].wr) ? rq[k][0].data : 32'h0;
      check($sformatf("addr_ok[%0d]", k), 32'(aok_s[k]), 32'(acc_e));
      check($sformatf("data_ok[%0d]", k), 32'(dok_s[k]), 32'(pop_e));
      check($sformatf("rdata[%0d]", k), rd_s[k], exp_rd);

      if (req_s[k] && aok_s[k]) begin
        acc_q[k].push_back(cyc);
        last_acc[k] = cyc;
      end
      if (dok_s[k]) ok_q[k].push_back(cyc);

      if (rst_s[k]) begin
        rq[k].delete();
        wait_m[k] = 0;
      end else begin
        if (pop_e) void'(rq[k].pop_front());
        if (acc_e) begin
          idx = int'(addr_s[k][11:2]);
          ent.due = cyc + dd_m[k];
          ent.wr  = wr_s[k];
          ent.data = wr_s[k] ? 32'h0 : mem_m[k][idx];
          if (wr_s[k]) begin
            for (int b = 0; b < 4; b++)
              if (strb_s[k][b]) mem_m[k][idx][8*b +: 8] = wd_s[k][8*b +: 8];
          end
          rq[k].push_back(ent);
        end
        if (acc_e || !req_s[k]) wait_m[k] = 0;
        else if (wait_m[k] < ad_m[k]) wait_m[k] = wait_m[k] + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k, input int n);
    req_s[k] = 1'b0;
    repeat (n) sync();
  endtask

  task automatic rst_pulse(input int k);
    req_s[k] = 1'b0;
    rst_s[k] = 1'b1;
    sync();
    rst_s[k] = 1'b0;
  endtask

  task automatic send(input int k, input bit wr, input logic [31:0] addr,
                      input logic [3:0] strb, input logic [31:0] wd);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    req_s[k]  = 1'b1;
    wr_s[k]   = wr;
    size_s[k] = 2'($urandom_range(0, 2));
    strb_s[k] = strb;
    addr_s[k] = addr;
    wd_s[k]   = wd;
    while (!done) begin
      @(negedge clk);
      if (aok_s[k]) done = 1'b1;
      sync();
      n++;
      if (!done && n > 60) begin
        check($sformatf("accept_timeout[%0d]", k), 32'(0), 32'(1));
        done = 1'b1;
      end
    end
    req_s[k] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int n0;
    int exp_acc [4];
    int exp_ok  [4];
    logic [31:0] a;
    exp_acc = '{0, 1, 3, 4};
    exp_ok  = '{3, 4, 6, 7};
    for (int k = 0; k < N; k++) begin
      rst_s[k] = 1'b1; req_s[k] = 1'b0; wr_s[k] = 1'b0; size_s[k] = 2'd0;
      strb_s[k] = 4'h0; addr_s[k] = 32'h0; wd_s[k] = 32'h0;
      wait_m[k] = 0; last_acc[k] = 0;
    end
    repeat (3) sync();
    for (int k = 0; k < N; k++) rst_s[k] = 1'b0;

    // Preload the first 32 words of every RAM so no read sees uninitialised data.
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 32; i++) send(k, 1'b1, 32'(i << 2), 4'hF, $urandom());
    idle(0, 4);

    // Instance A (DATA_DELAY=1): single read, byte merge, upper address bits.
    send(0, 1'b1, 32'h10, 4'hF, 32'h1234_5678);
    send(0, 1'b0, 32'h10, 4'h0, 32'h0);
    @(negedge clk);
    check("single_rd_ok", 32'(dok_s[0]), 32'(1));
    check("single_rd_data", rd_s[0], 32'h1234_5678);
    @(negedge clk);
    check("single_rd_low", 32'(dok_s[0]), 32'(0));
    sync();
    send(0, 1'b1, 32'h10, 4'b0010, 32'hAAAA_AAAA);
    @(negedge clk);
    check("wr_resp_ok", 32'(dok_s[0]), 32'(1));
    check("wr_resp_rdata", rd_s[0], 32'h0);
    sync();
    send(0, 1'b0, 32'h10, 4'h0, 32'h0);
    @(negedge clk);
    check("byte_merge", rd_s[0], 32'h1234_AA78);
    sync();
    send(0, 1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF);
    send(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
    @(negedge clk);
    check("alias_rd", rd_s[0], 32'hDEAD_BEEF);
    sync();

    // Instance B (DEPTH=2, DATA_DELAY=3): backpressure timing.
    idle(1, 4);
    acc_q[1].delete();
    ok_q[1].delete();
    t0 = cyc;
    for (int i = 0; i < 4; i++) send(1, 1'b0, 32'(i << 2), 4'h0, 32'h0);
    idle(1, 8);
    check("bp_accepts", 32'(acc_q[1].size()), 32'(4));
    check("bp_responses", 32'(ok_q[1].size()), 32'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < acc_q[1].size()) check($sformatf("bp_acc%0d", i), 32'(acc_q[1][i] - t0), 32'(exp_acc[i]));
      if (i < ok_q[1].size())  check($sformatf("bp_ok%0d", i), 32'(ok_q[1][i] - t0), 32'(exp_ok[i]));
    end

    // Instance B: reset with two reads in flight.
    send(1, 1'b1, 32'h14, 4'hF, 32'hCAFE_F00D);
    idle(1, 5);
    n0 = ok_q[1].size();
    send(1, 1'b0, 32'h0, 4'h0, 32'h0);
    send(1, 1'b0, 32'h4, 4'h0, 32'h0);
    rst_pulse(1);
    idle(1, 10);
    check("rst_no_data_ok", 32'(ok_q[1].size() - n0), 32'(0));
    send(1, 1'b0, 32'h14, 4'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rst_ram_kept_ok", 32'(dok_s[1]), 32'(1));
    check("rst_ram_kept", rd_s[1], 32'hCAFE_F00D);
    sync();

    // Instance C (ADDR_DELAY=2): hold delay, then restart after a dropped req.
    idle(2, 4);
    t0 = cyc;
    send(2, 1'b0, 32'h8, 4'h0, 32'h0);
    check("addr_delay_held", 32'(last_acc[2] - t0), 32'(2));
    idle(2, 4);
    t0 = cyc;
    req_s[2] = 1'b1; wr_s[2] = 1'b0; addr_s[2] = 32'hC;
    sync();
    req_s[2] = 1'b0;
    sync();
    send(2, 1'b0, 32'hC, 4'h0, 32'h0);
    check("addr_delay_restart", 32'(last_acc[2] - t0 - 2), 32'(2));
    idle(2, 4);

    // Randomised traffic on every instance; the model checks each cycle.
    for (int k = 0; k < N; k++) begin
      for (int n = 0; n < 150; n++) begin
        a = $urandom();
        a[11:2] = 10'($urandom_range(0, 31));
        send(k, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom());
        if ($urandom_range(0, 3) == 0) idle(k, $urandom_range(1, 4));
        if ($urandom_range(0, 59) == 0) rst_pulse(k);
      end
      idle(k, 10);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
